// File: rtl/usb_rx_decoder.sv
// Low-speed USB receive decoder: SYNC detect, NRZI decode, bit unstuffing,
// LSB-first byte assembly and EOP detection, advanced one recovered bit per strobe.

package types;
  typedef enum logic [1:0] {
    SE0 = 2'b00,
    J   = 2'b01,
    K   = 2'b10,
    SE1 = 2'b11
  } d_port_t;
endpackage

// Handshake: rx_valid is a one-clk qualifier for rx_data with no ready/backpressure;
// the packet layer must take the byte in the cycle rx_valid is high.
module usb_rx_decoder #(
  parameter int SYNC_MIN_ZEROS = 4,
  parameter int STUFF_LEN      = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          strobe,
  input  types::d_port_t q,
  output logic [7:0]    rx_data,
  output logic          rx_valid,
  output logic          rx_active,
  output logic          rx_error,
  output logic          eop,
  output logic [2:0]    dbg_state
);
  import types::*;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SYNC  = 3'd1,
    S_DATA  = 3'd2,
    S_EOP   = 3'd3,
    S_ABORT = 3'd4
  } state_t;

  localparam int OW = $clog2(STUFF_LEN + 1);
  localparam logic [OW-1:0] STUFF_CNT = STUFF_LEN[OW-1:0];
  localparam logic [2:0]    ZMIN      = SYNC_MIN_ZEROS[2:0];

  state_t        state, state_n;
  d_port_t       prev, prev_n;
  logic [2:0]    zcnt, zcnt_n;
  logic [OW-1:0] ones, ones_n;
  logic [2:0]    bcnt, bcnt_n;
  logic [7:0]    sr, sr_n;
  logic          abort_se0, abort_se0_n;
  logic [7:0]    rx_data_n;
  logic          rx_valid_n, rx_active_n, rx_error_n, eop_n;

  logic       is_jk;
  logic       bit_d;
  logic [7:0] shifted;

  assign is_jk     = (q == J) || (q == K);
  assign bit_d     = (q == prev);
  assign shifted   = {bit_d, sr[7:1]};
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      prev      <= J;
      zcnt      <= '0;
      ones      <= '0;
      bcnt      <= '0;
      sr        <= '0;
      abort_se0 <= 1'b0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      rx_active <= 1'b0;
      rx_error  <= 1'b0;
      eop       <= 1'b0;
    end else begin
      state     <= state_n;
      prev      <= prev_n;
      zcnt      <= zcnt_n;
      ones      <= ones_n;
      bcnt      <= bcnt_n;
      sr        <= sr_n;
      abort_se0 <= abort_se0_n;
      rx_data   <= rx_data_n;
      rx_valid  <= rx_valid_n;
      rx_active <= rx_active_n;
      rx_error  <= rx_error_n;
      eop       <= eop_n;
    end
  end

  always_comb begin
    state_n     = state;
    prev_n      = prev;
    zcnt_n      = zcnt;
    ones_n      = ones;
    bcnt_n      = bcnt;
    sr_n        = sr;
    abort_se0_n = abort_se0;
    rx_data_n   = rx_data;
    rx_active_n = rx_active;
    rx_valid_n  = 1'b0;
    rx_error_n  = 1'b0;
    eop_n       = 1'b0;

    if (strobe) begin
      if (is_jk) prev_n = q;
      case (state)
        S_IDLE: begin
          if (q == K) begin
            zcnt_n  = 3'd1;
            state_n = S_SYNC;
          end
        end
        S_SYNC: begin
          if (!is_jk) begin
            state_n = S_IDLE;
          end else if (!bit_d) begin
            if (zcnt != 3'd7) zcnt_n = zcnt + 3'd1;
          end else if (zcnt >= ZMIN) begin
            state_n     = S_DATA;
            rx_active_n = 1'b1;
            bcnt_n      = '0;
            ones_n      = '0;
          end else begin
            state_n = S_IDLE;
          end
        end
        S_DATA: begin
          case (q)
            SE0: begin
              state_n    = S_EOP;
              rx_error_n = (bcnt != 3'd0);
              bcnt_n     = '0;
            end
            SE1: begin
              rx_error_n  = 1'b1;
              state_n     = S_ABORT;
              abort_se0_n = 1'b0;
            end
            default: begin
              // After STUFF_LEN ones the next bit must be a stuffed 0, never data.
              if (ones == STUFF_CNT) begin
                if (bit_d) begin
                  rx_error_n  = 1'b1;
                  state_n     = S_ABORT;
                  abort_se0_n = 1'b0;
                end else begin
                  ones_n = '0;
                end
              end else begin
                sr_n   = shifted;
                ones_n = bit_d ? ones + 1'b1 : '0;
                if (bcnt == 3'd7) begin
                  rx_data_n  = shifted;
                  rx_valid_n = 1'b1;
                  bcnt_n     = '0;
                end else begin
                  bcnt_n = bcnt + 3'd1;
                end
              end
            end
          endcase
        end
        S_EOP: begin
          if (q == J) begin
            eop_n       = 1'b1;
            rx_active_n = 1'b0;
            state_n     = S_IDLE;
          end else if (q != SE0) begin
            rx_error_n  = 1'b1;
            state_n     = S_ABORT;
            abort_se0_n = 1'b0;
          end
        end
        S_ABORT: begin
          // Leave only on an SE0 directly followed by J, without flagging eop.
          if (q == SE0) begin
            abort_se0_n = 1'b1;
          end else if (q == J && abort_se0) begin
            rx_active_n = 1'b0;
            abort_se0_n = 1'b0;
            state_n     = S_IDLE;
          end else begin
            abort_se0_n = 1'b0;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_rx_decoder.sv
// Bench for usb_rx_decoder: NRZI/stuffed packets built from bytes, expected
// bytes and pulse counts derived from the decoded bit stream by a list-based model.

module tb_usb_rx_decoder;
  import types::*;

  localparam int M_CLEAN   = 0;
  localparam int M_PARTIAL = 1;
  localparam int M_STUFF   = 2;
  localparam int M_SE1     = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       strobe;
  d_port_t    q;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_active;
  logic       rx_error;
  logic       eop;
  logic [2:0] dbg_state;

  usb_rx_decoder dut (
    .clk       (clk),
    .reset     (reset),
    .strobe    (strobe),
    .q         (q),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_active (rx_active),
    .rx_error  (rx_error),
    .eop       (eop),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         eop_cnt  = 0;
  int         err_cnt  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] pkt_bytes[$];
  bit         bits_q[$];
  int         gen_run;
  d_port_t    line;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // scoreboard: every rx_valid pops one expected byte
  always @(negedge clk) begin
    if (eop) eop_cnt++;
    if (rx_error) err_cnt++;
    if (rx_valid) begin
      check("valid_without_eop", {31'd0, eop}, 32'd0);
      if (exp_q.size() == 0) check("unexpected_valid", {31'd0, rx_valid}, 32'd0);
      else check("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
    end
  end

  // drivers
  task automatic send_sym(input d_port_t s);
    @(negedge clk);
    q      = s;
    strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  task automatic send_bit(input bit b);
    if (!b) begin
      if (line == J) line = K;
      else line = J;
    end
    send_sym(line);
  endtask

  task automatic add_bit(input bit b);
    bits_q.push_back(b);
    if (b) gen_run++;
    else gen_run = 0;
    if (gen_run == 6) begin
      bits_q.push_back(1'b0);
      gen_run = 0;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rx_data"},   {24'd0, rx_data},   32'd0);
    check({tag, "_rx_valid"},  {31'd0, rx_valid},  32'd0);
    check({tag, "_rx_active"}, {31'd0, rx_active}, 32'd0);
    check({tag, "_rx_error"},  {31'd0, rx_error},  32'd0);
    check({tag, "_eop"},       {31'd0, eop},       32'd0);
  endtask

  task automatic run_packet(input int nz, input int mode, input int nextra);
    int         run;
    int         nbits;
    int         e0;
    int         x0;
    int         exp_err;
    int         exp_eop;
    bit         stuff_err;
    logic [7:0] acc;
    bits_q.delete();
    gen_run = 0;
    foreach (pkt_bytes[i]) for (int k = 0; k < 8; k++) add_bit(pkt_bytes[i][k]);
    if (mode == M_PARTIAL) for (int k = 0; k < nextra; k++) add_bit(1'($urandom_range(0, 1)));
    if (mode == M_STUFF) repeat (7) bits_q.push_back(1'b1);

    // reference: strip stuffing from the decoded stream, cut bytes, find errors
    run = 0; nbits = 0; stuff_err = 1'b0; acc = 8'h00;
    for (int i = 0; i < bits_q.size() && !stuff_err; i++) begin
      if (run == 6) begin
        if (bits_q[i]) stuff_err = 1'b1;
        else run = 0;
      end else begin
        acc[nbits] = bits_q[i];
        nbits++;
        run = bits_q[i] ? run + 1 : 0;
        if (nbits == 8) begin
          exp_q.push_back(acc);
          nbits = 0;
        end
      end
    end
    exp_err = (stuff_err || mode == M_SE1 || nbits != 0) ? 1 : 0;
    exp_eop = (!stuff_err && mode != M_SE1) ? 1 : 0;

    e0 = err_cnt;
    x0 = eop_cnt;
    line = J;
    repeat (2) send_sym(J);
    check("active_idle", {31'd0, rx_active}, 32'd0);
    for (int k = 0; k < nz; k++) send_bit(1'b0);
    @(negedge clk);
    q      = line;
    strobe = 1'b1;
    check("active_pre_sync", {31'd0, rx_active}, 32'd0);
    @(negedge clk);
    strobe = 1'b0;
    check("active_post_sync", {31'd0, rx_active}, 32'd1);
    foreach (bits_q[i]) send_bit(bits_q[i]);
    if (mode == M_SE1) begin
      send_sym(SE1);
      send_sym(SE0);
    end else begin
      send_sym(SE0);
      send_sym(SE0);
    end
    send_sym(J);
    line = J;
    repeat (3) @(negedge clk);
    check("active_end", {31'd0, rx_active}, 32'd0);
    check("err_pulses", err_cnt - e0, exp_err);
    check("eop_pulses", eop_cnt - x0, exp_eop);
    check("bytes_left", exp_q.size(), 32'd0);
  endtask

  initial begin
    int e0;
    int x0;
    int nb;
    reset  = 1'b1;
    strobe = 1'b0;
    q      = J;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;

    // full SYNC, 0xA5
    pkt_bytes = '{8'hA5};
    run_packet(7, M_CLEAN, 0);
    // SYNC with leading symbols lost, 0x3C
    pkt_bytes = '{8'h3C};
    run_packet(5, M_CLEAN, 0);
    // two stuffed bits across 0xFF 0xFF
    pkt_bytes = '{8'hFF, 8'hFF};
    run_packet(7, M_CLEAN, 0);
    // seven ones without stuffing
    pkt_bytes.delete();
    run_packet(7, M_STUFF, 0);
    // 12 data bits then EOP
    pkt_bytes = '{8'hC3};
    run_packet(7, M_PARTIAL, 4);
    // SE1 inside data
    pkt_bytes = '{8'h81};
    run_packet(6, M_SE1, 0);

    // too few SYNC zeros: no packet starts
    e0 = err_cnt;
    line = J;
    send_sym(J);
    repeat (3) send_bit(1'b0);
    send_bit(1'b1);
    check("short_sync_active", {31'd0, rx_active}, 32'd0);
    line = J;
    repeat (2) send_sym(J);
    check("short_sync_err", err_cnt - e0, 32'd0);

    // reset mid-byte aborts silently
    e0 = err_cnt;
    x0 = eop_cnt;
    line = J;
    send_sym(J);
    repeat (7) send_bit(1'b0);
    send_bit(1'b1);
    repeat (4) send_bit(1'($urandom_range(0, 1)));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle_outputs("mid_reset");
    q = J;
    repeat (4) @(negedge clk);
    check("mid_reset_err", err_cnt - e0, 32'd0);
    check("mid_reset_eop", eop_cnt - x0, 32'd0);
    pkt_bytes = '{8'h5A};
    run_packet(7, M_CLEAN, 0);

    // randomized packets
    for (int n = 0; n < 24; n++) begin
      int mode;
      mode = $urandom_range(0, 3);
      nb   = (mode == M_CLEAN) ? $urandom_range(1, 5) : $urandom_range(0, 4);
      pkt_bytes.delete();
      for (int b = 0; b < nb; b++)
        pkt_bytes.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom_range(0, 255)));
      run_packet($urandom_range(4, 7), mode, $urandom_range(1, 7));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
